// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SETTLE_DEFAULT = 2;

    // Number of truth-table entries for an n-input gate.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts 0..SETTLE while enabled and flags the terminal count,
// wrapping back to 0 on the terminal cycle so the next vector starts fresh.
module tt_settle_timer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == CNT_W'(SETTLE));

    // Counter register: clear dominates, otherwise count and wrap at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input combination of an N_IN-input gate in ascending order,
// samples the gate output after a settle time and compares the measured
// truth table against a latched golden table.
//
// state | meaning
// IDLE  | waiting for start; results from the last sweep held
// APPLY | driving dut_in=idx, sampling dut_out at settle terminal count
// DONE  | one-cycle done pulse, dut_in back to 0
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = SETTLE_DEFAULT,
    localparam int TT_W  = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] captured_tt,
    output logic [TT_W-1:0] mismatch_mask
);

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic [TT_W-1:0] expected_lat;
    logic            tc;
    logic            sample;

    // A sample is taken only at terminal count; abort wins over it.
    assign sample = (state == APPLY) && tc && !abort;

    tt_settle_timer #(
        .SETTLE (SETTLE),
        .CNT_W  (8)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != APPLY),
        .enable ((state == APPLY) && !abort),
        .tc     (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        dut_in    = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = APPLY;
            end
            APPLY: begin
                busy   = 1'b1;
                dut_in = idx;
                if (abort)                          state_nxt = IDLE;
                else if (tc && (idx == IDX_LAST))   state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep index, golden-table latch and capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            expected_lat <= '0;
            captured_tt  <= '0;
        end else if (state == IDLE && start) begin
            idx          <= '0;
            expected_lat <= expected_tt;
            captured_tt  <= '0;
        end else if (sample) begin
            captured_tt[idx] <= dut_out;
            if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
    end

    assign mismatch_mask = captured_tt ^ expected_lat;
    assign pass          = (captured_tt == expected_lat);

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [15:0] exp0 = '0, exp1 = '0, gate0 = '0, gate1 = '0;
    logic [3:0]  dut_in0, dut_in1;
    logic        dut_out0, dut_out1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] cap0, mm0, cap1, mm1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural gate models: output is the gate's truth-table bit at the applied input.
    assign dut_out0 = gate0[dut_in0];
    assign dut_out1 = gate1[dut_in1];

    tt_sweep_checker #(.N_IN(4), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .expected_tt(exp0), .dut_in(dut_in0), .dut_out(dut_out0),
        .busy(busy0), .done(done0), .pass(pass0),
        .captured_tt(cap0), .mismatch_mask(mm0));

    tt_sweep_checker #(.N_IN(4), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expected_tt(exp1), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1),
        .captured_tt(cap1), .mismatch_mask(mm1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    function automatic logic [3:0]  g_din(input int w);  return w ? dut_in1 : dut_in0; endfunction
    function automatic logic        g_busy(input int w); return w ? busy1 : busy0;     endfunction
    function automatic logic        g_done(input int w); return w ? done1 : done0;     endfunction
    function automatic logic        g_pass(input int w); return w ? pass1 : pass0;     endfunction
    function automatic logic [15:0] g_cap(input int w);  return w ? cap1 : cap0;       endfunction
    function automatic logic [15:0] g_mm(input int w);   return w ? mm1 : mm0;         endfunction

    task automatic drive(input int w, input logic st, input logic [15:0] e);
        if (w != 0) begin start1 = st; exp1 = e; end
        else        begin start0 = st; exp0 = e; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on instance w; reference: vector k held SETTLE+1 cycles,
    // done after 16*(SETTLE+1) edges, captured table equals the gate table.
    task automatic sweep(input int w, input logic [15:0] gate, input logic [15:0] e,
                         input bit poke_busy_start);
        int settle;
        int lat;
        int cycles;
        int bad_hist;
        int bad_busy;
        logic [3:0] hist[$];
        settle = (w != 0) ? 0 : 2;
        lat    = 16 * (settle + 1);
        if (w != 0) gate1 = gate; else gate0 = gate;
        drive(w, 1'b1, e);
        step();
        drive(w, 1'b0, e);
        hist.push_back(g_din(w));
        cycles   = 0;
        bad_busy = (g_busy(w) !== 1'b1) ? 1 : 0;
        while (cycles < 400) begin
            step();
            cycles++;
            if (g_done(w) === 1'b1) break;
            if (g_busy(w) !== 1'b1) bad_busy++;
            hist.push_back(g_din(w));
            if (poke_busy_start && cycles == 10) drive(w, 1'b1, ~e);
            if (poke_busy_start && cycles == 11) drive(w, 1'b0, e);
        end
        chk($sformatf("w%0d_latency", w), cycles, lat);
        chk($sformatf("w%0d_busy_during", w), bad_busy, 0);
        chk($sformatf("w%0d_busy_in_done", w), g_busy(w), 1'b0);
        chk($sformatf("w%0d_din_in_done", w), g_din(w), 4'd0);
        bad_hist = (hist.size() == lat) ? 0 : 1;
        foreach (hist[i]) if (hist[i] !== 4'(i / (settle + 1))) bad_hist++;
        chk($sformatf("w%0d_din_sequence", w), bad_hist, 0);
        chk($sformatf("w%0d_captured", w), g_cap(w), gate);
        chk($sformatf("w%0d_pass", w), g_pass(w), (gate == e));
        chk($sformatf("w%0d_mask", w), g_mm(w), gate ^ e);
        // A start in the DONE cycle is ignored and results hold.
        drive(w, 1'b1, ~e);
        step();
        drive(w, 1'b0, e);
        chk($sformatf("w%0d_start_in_done_ignored", w), g_busy(w), 1'b0);
        chk($sformatf("w%0d_done_one_cycle", w), g_done(w), 1'b0);
        chk($sformatf("w%0d_captured_hold", w), g_cap(w), gate);
        chk($sformatf("w%0d_mask_hold", w), g_mm(w), gate ^ e);
    endtask

    task automatic wait_din0(input logic [3:0] v, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dut_in0 === v) begin found = 1'b1; break; end
            step();
        end
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] g;
        logic [15:0] e;
        bit found;
        int dones;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_din", dut_in0, 4'd0);
        chk("rst_captured", cap0, 16'h0000);
        chk("rst_pass", pass0, 1'b1);
        chk("rst_mask", mm0, 16'h0000);
        rst_n = 1'b1;
        step();

        // 0x822B gate, matching and off-by-one-bit golden tables; busy start ignored.
        sweep(0, 16'h822B, 16'h822B, 1'b1);
        sweep(0, 16'h822B, 16'h822A, 1'b0);
        chk("t2_mask_exact", mm0, 16'h0001);
        // Constant-1 output, SETTLE=0.
        sweep(1, 16'hFFFF, 16'hFFFF, 1'b0);

        // Randomized gates and golden tables on both settle settings.
        for (int r = 0; r < 4; r++) begin
            g = 16'($urandom);
            e = (r[0]) ? g : (g ^ (16'h1 << $urandom_range(15)));
            sweep(0, g, e, r == 2);
            g = 16'($urandom);
            e = (r[0]) ? (g ^ 16'($urandom)) : g;
            sweep(1, g, e, 1'b0);
        end

        // Abort on the edge that would sample vector 5: bits 0..4 only.
        g = 16'($urandom) | 16'h0020;
        gate0 = g;
        drive(0, 1'b1, 16'h1234);
        step();
        drive(0, 1'b0, 16'h1234);
        wait_din0(4'd5, found);
        chk("abort_reach_5", found, 1'b1);
        step();
        step();
        chk("abort_still_5", dut_in0, 4'd5);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_din", dut_in0, 4'd0);
        chk("abort_done", done0, 1'b0);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done0 === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_partial", cap0, g & 16'h001F);
        // Abort in IDLE is harmless, and start beats a same-cycle abort.
        abort0 = 1'b1;
        drive(0, 1'b1, 16'hBEEF);
        step();
        abort0 = 1'b0;
        drive(0, 1'b0, 16'hBEEF);
        chk("start_beats_abort", busy0, 1'b1);
        for (int i = 0; i < 200 && done0 !== 1'b1; i++) step();
        chk("start_beats_abort_done", done0, 1'b1);
        step();
        sweep(0, 16'h822B, 16'h822B, 1'b0);

        // Asynchronous reset mid-sweep at idx 9.
        g = 16'($urandom);
        gate0 = g;
        drive(0, 1'b1, g);
        step();
        drive(0, 1'b0, g);
        wait_din0(4'd9, found);
        chk("rst_reach_9", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_done", done0, 1'b0);
        chk("midrst_din", dut_in0, 4'd0);
        chk("midrst_captured", cap0, 16'h0000);
        chk("midrst_pass", pass0, 1'b1);
        #2;
        rst_n = 1'b1;
        step();
        sweep(0, g, g, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Upstream stimulus and capture stage for a synthesized N-input truth-table gate netlist, e.g. the 4-input gate 0x822B.
- Drives every input combination in ascending order into the gate and samples the single gate output after a programmable settle time.
- Assembles the measured truth table and compares it against an expected hex truth table.
- Reports pass/fail plus a per-minterm mismatch mask. Used in the design-validation harness ahead of netlist sign-off.

Parameters:
- N_IN, 4, number of gate inputs; TT_W = 2**N_IN truth-table bits (16 at default).
- SETTLE, 2, extra cycles each vector is held before sampling. Legal range 0..255.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; honoured only when busy=0.
- abort  in  1  cancel an in-progress sweep.
- expected_tt  in  TT_W  golden truth table; bit i = required output for input value i. Sampled on the accepting start edge.
- dut_in  out  N_IN  vector driven to the gate; bit k drives gate input k.
- dut_out  in  1  gate output.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse: sweep complete, results valid.
- pass  out  1  1 iff captured_tt == latched expected_tt.
- captured_tt  out  TT_W  measured truth table.
- mismatch_mask  out  TT_W  captured_tt XOR latched expected_tt.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All of the following clear to 0: dut_in, busy, done, captured_tt, latched expected, settle counter, index.
  - Consequently pass=1 and mismatch_mask=0 after reset; results are only meaningful after a done pulse.
- States are IDLE, APPLY, DONE.
- IDLE
  - start=1 at edge E0: latch expected_tt, clear captured_tt, idx=0, cnt=0, busy=1, go to APPLY.
- APPLY
  - dut_in=idx, held for SETTLE+1 cycles. cnt counts 0..SETTLE.
  - At the edge where cnt==SETTLE: captured_tt[idx] <= dut_out and cnt <= 0.
    - If idx == TT_W-1: go to DONE and assert done.
    - Otherwise: idx <= idx+1.
  - Vector k is therefore sampled at edge E0+(k+1)*(SETTLE+1).
  - The last sample and done both occur at E0+TT_W*(SETTLE+1): 48 edges at default parameters, 16 with SETTLE=0.
- DONE (one cycle)
  - done=1, busy=0, dut_in returns to 0, then unconditionally go to IDLE.
  - A start arriving in the DONE cycle is ignored.
- pass and mismatch_mask are combinational from registered captured_tt and latched expected. They hold their values until the next accepted start.
- start while busy=1 is ignored; the sweep is not restarted.
- abort=1 in APPLY: next state IDLE, busy=0, dut_in=0, no done pulse, captured_tt left partial.
  - abort has priority over a same-cycle sample.
  - abort in IDLE or DONE has no effect.
- abort and start in the same IDLE cycle: start wins.
- rst_n asserted mid-sweep: immediate return to the reset values above; no done pulse.
- idx is N_IN bits wide with no wrap. Termination is by comparison with TT_W-1, never by overflow.
- dut_out is treated as a synchronous input already settled; there is no synchronizer inside.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum {IDLE, APPLY, DONE};
  - a function tt_width(n) = 2**n;
  - a localparam for the default SETTLE.
- One sub-module, tt_settle_timer: a load/clear counter that flags terminal count SETTLE. The top-level FSM and capture register use it.

Test Plan:
1. Behavioural 0x822B gate model on dut_out, expected_tt=0x822B, SETTLE=2 -> done exactly 48 edges after start, pass=1, captured_tt=0x822B, mismatch_mask=0x0000.
2. Same model, expected_tt=0x822A -> pass=0, mismatch_mask=0x0001, captured_tt=0x822B.
3. dut_out tied 1, expected_tt=0xFFFF, SETTLE=0 -> done 16 edges after start, dut_in steps 0..15 one per cycle, pass=1.
4. SETTLE=2, monitor dut_in -> each value 0..15 held exactly 3 cycles, returns to 0 in the DONE cycle; a second start while busy changes nothing.
5. abort asserted while dut_in=5 -> busy=0 and dut_in=0 next cycle, no done pulse; a following start completes normally.
6. rst_n pulsed low mid-sweep (idx=9) -> busy, done, dut_in and captured_tt zero immediately, without waiting for a clock edge; after release, a start yields a full correct sweep.
